// File: rtl/frame_tx_scheduler.sv
// Forwards frames from a receive buffer to a byte-wide transmitter, prepending an
// optional preamble, dropping bad or out-of-range frames and spacing frames by an IFG.
module frame_tx_scheduler #(
  parameter int IFG_CYCLES  = 12,
  parameter int MIN_LEN     = 64,
  parameter int MAX_LEN     = 1518,
  parameter bit PREAMBLE_EN = 1'b1
) (
  input  logic        RAM_Clk_Read,
  input  logic        RST,
  input  logic        New_Frame,
  input  logic [10:0] FIFO_Data_Num,
  input  logic [7:0]  RAM_Dataout,
  input  logic        Frame_Bad,
  input  logic        Tx_Ready,
  output logic        RD_EN,
  output logic [7:0]  Tx_Data,
  output logic        Tx_Valid,
  output logic        Tx_SOF,
  output logic        Tx_EOF,
  output logic        Busy,
  output logic [15:0] Frame_Cnt,
  output logic [15:0] Drop_Cnt,
  output logic        Overrun
);

  typedef enum logic [2:0] {IDLE, LOAD, PRE, DATA, DRAIN, IFG} state_t;

  localparam logic [11:0] MIN_LEN_W = 12'(MIN_LEN);
  localparam logic [11:0] MAX_LEN_W = 12'(MAX_LEN);
  localparam logic [15:0] IFG_LOAD  = 16'((IFG_CYCLES > 0) ? (IFG_CYCLES - 1) : 0);

  state_t      state_reg;
  logic [10:0] len_reg;
  logic [10:0] remaining_reg;
  logic [2:0]  pre_idx_reg;
  logic [15:0] ifg_cnt_reg;
  logic        pending_reg;
  logic        overrun_reg;
  logic        beat_reg;
  logic        beat_first_reg;
  logic        beat_last_reg;
  logic [15:0] frame_cnt_reg;
  logic [15:0] drop_cnt_reg;

  logic [7:0]  pre_rom [8];
  logic        pre_beat;
  logic        rd_req;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_pre_rom
      assign pre_rom[gi] = (gi == 7) ? 8'hD5 : 8'h55;
    end
  endgenerate

  // Preamble beats and buffer reads are granted in the same cycle as Tx_Ready;
  // a data beat follows its read by one cycle, when RAM_Dataout becomes valid.
  assign pre_beat = (state_reg == PRE) && Tx_Ready;
  assign rd_req   = (((state_reg == DATA) && Tx_Ready) || (state_reg == DRAIN))
                    && (remaining_reg != 11'd0);

  assign RD_EN     = rd_req;
  assign Tx_Valid  = pre_beat | beat_reg;
  assign Tx_Data   = beat_reg ? RAM_Dataout : (pre_beat ? pre_rom[pre_idx_reg] : 8'h00);
  assign Tx_SOF    = (pre_beat && (pre_idx_reg == 3'd0)) || (beat_reg && beat_first_reg);
  assign Tx_EOF    = beat_reg && beat_last_reg;
  assign Busy      = (state_reg != IDLE);
  assign Frame_Cnt = frame_cnt_reg;
  assign Drop_Cnt  = drop_cnt_reg;
  assign Overrun   = overrun_reg;

  always_ff @(posedge RAM_Clk_Read) begin
    if (RST) begin
      state_reg      <= IDLE;
      len_reg        <= 11'd0;
      remaining_reg  <= 11'd0;
      pre_idx_reg    <= 3'd0;
      ifg_cnt_reg    <= 16'd0;
      pending_reg    <= 1'b0;
      overrun_reg    <= 1'b0;
      beat_reg       <= 1'b0;
      beat_first_reg <= 1'b0;
      beat_last_reg  <= 1'b0;
      frame_cnt_reg  <= 16'd0;
      drop_cnt_reg   <= 16'd0;
    end else begin
      beat_reg       <= rd_req && (state_reg == DATA);
      beat_first_reg <= !PREAMBLE_EN && (remaining_reg == len_reg);
      beat_last_reg  <= (remaining_reg == 11'd1);
      if (rd_req) begin
        remaining_reg <= remaining_reg - 11'd1;
      end

      // A second arrival while one is already queued cannot be held: flag it.
      if (New_Frame && (state_reg != IDLE)) begin
        if (pending_reg) begin
          overrun_reg <= 1'b1;
        end else begin
          pending_reg <= 1'b1;
        end
      end

      case (state_reg)
        IDLE: begin
          if (New_Frame || pending_reg) begin
            state_reg <= LOAD;
            if (!New_Frame) begin
              pending_reg <= 1'b0;
            end
          end
        end
        LOAD: begin
          len_reg       <= FIFO_Data_Num;
          remaining_reg <= FIFO_Data_Num;
          pre_idx_reg   <= 3'd0;
          if (FIFO_Data_Num == 11'd0) begin
            state_reg <= IDLE;
            if (drop_cnt_reg != 16'hFFFF) begin
              drop_cnt_reg <= drop_cnt_reg + 16'd1;
            end
          end else if (Frame_Bad || ({1'b0, FIFO_Data_Num} < MIN_LEN_W)
                       || ({1'b0, FIFO_Data_Num} > MAX_LEN_W)) begin
            state_reg <= DRAIN;
          end else begin
            state_reg <= PREAMBLE_EN ? PRE : DATA;
          end
        end
        PRE: begin
          if (Tx_Ready) begin
            pre_idx_reg <= pre_idx_reg + 3'd1;
            if (pre_idx_reg == 3'd7) begin
              state_reg <= DATA;
            end
          end
        end
        DATA: begin
          if (beat_reg && beat_last_reg) begin
            state_reg   <= (IFG_CYCLES > 0) ? IFG : IDLE;
            ifg_cnt_reg <= IFG_LOAD;
            if (frame_cnt_reg != 16'hFFFF) begin
              frame_cnt_reg <= frame_cnt_reg + 16'd1;
            end
          end
        end
        DRAIN: begin
          if (remaining_reg == 11'd1) begin
            state_reg <= IDLE;
            if (drop_cnt_reg != 16'hFFFF) begin
              drop_cnt_reg <= drop_cnt_reg + 16'd1;
            end
          end
        end
        IFG: begin
          if (ifg_cnt_reg == 16'd0) begin
            state_reg <= IDLE;
          end else begin
            ifg_cnt_reg <= ifg_cnt_reg - 16'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_tx_scheduler.sv
// Randomised bench for frame_tx_scheduler: a buffer model feeds frames, a monitor records
// every beat and read, and each scenario compares against a stream built from the frame rules.
`timescale 1ns/1ps
module tb_frame_tx_scheduler;

  localparam int IFG  = 12;
  localparam int MINL = 64;
  localparam int MAXL = 1518;
  localparam bit PRE_EN = 1'b1;
  localparam int NPRE = PRE_EN ? 8 : 0;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic        New_Frame = 1'b0;
  logic [10:0] FIFO_Data_Num = 11'd0;
  logic [7:0]  RAM_Dataout = 8'h00;
  logic        Frame_Bad = 1'b0;
  logic        Tx_Ready = 1'b1;
  logic        RD_EN;
  logic [7:0]  Tx_Data;
  logic        Tx_Valid;
  logic        Tx_SOF;
  logic        Tx_EOF;
  logic        Busy;
  logic [15:0] Frame_Cnt;
  logic [15:0] Drop_Cnt;
  logic        Overrun;

  frame_tx_scheduler #(
    .IFG_CYCLES(IFG), .MIN_LEN(MINL), .MAX_LEN(MAXL), .PREAMBLE_EN(PRE_EN)
  ) dut (
    .RAM_Clk_Read(clk), .RST(RST), .New_Frame(New_Frame), .FIFO_Data_Num(FIFO_Data_Num),
    .RAM_Dataout(RAM_Dataout), .Frame_Bad(Frame_Bad), .Tx_Ready(Tx_Ready), .RD_EN(RD_EN),
    .Tx_Data(Tx_Data), .Tx_Valid(Tx_Valid), .Tx_SOF(Tx_SOF), .Tx_EOF(Tx_EOF), .Busy(Busy),
    .Frame_Cnt(Frame_Cnt), .Drop_Cnt(Drop_Cnt), .Overrun(Overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int exp_frames = 0;
  int exp_drops = 0;
  int ready_mode = 0;

  logic [7:0] mem [0:4095];
  int  rd_ptr = 0;
  bit  ram_req = 1'b0;

  logic [7:0] obs_data[$];
  bit         obs_sof[$];
  bit         obs_eof[$];
  int         sof_cyc_q[$];
  int         eof_cyc_q[$];
  int cyc = 0;
  int rd_cnt = 0, rd_first = -1, rd_last = -1, rd_gap = 0, inv_viol = 0;
  int busy_rise = -1, busy_fall = -1;
  bit prev_busy = 1'b0;

  // Monitor: samples all outputs on the falling edge.
  initial forever begin
    @(negedge clk);
    cyc++;
    ram_req = RD_EN;
    if (Tx_Valid) begin
      obs_data.push_back(Tx_Data);
      obs_sof.push_back(Tx_SOF);
      obs_eof.push_back(Tx_EOF);
      if (Tx_SOF) sof_cyc_q.push_back(cyc);
      if (Tx_EOF) eof_cyc_q.push_back(cyc);
    end else if (Tx_Data !== 8'h00 || Tx_SOF !== 1'b0 || Tx_EOF !== 1'b0) begin
      inv_viol++;
    end
    if (RD_EN) begin
      if (rd_cnt == 0) rd_first = cyc;
      else if (rd_last != cyc - 1) rd_gap++;
      rd_cnt++;
      rd_last = cyc;
    end
    if (Busy && !prev_busy) busy_rise = cyc;
    if (!Busy && prev_busy) busy_fall = cyc;
    prev_busy = Busy;
  end

  // Receive buffer: data for a read appears in the following cycle; garbage otherwise.
  initial forever begin
    @(posedge clk);
    #1;
    if (ram_req) begin
      RAM_Dataout = mem[rd_ptr % 4096];
      rd_ptr++;
    end else begin
      RAM_Dataout = 8'($urandom);
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0: Tx_Ready = 1'b1;
      1: Tx_Ready = !Tx_Ready;
      default: Tx_Ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic clear_mon;
    obs_data.delete(); obs_sof.delete(); obs_eof.delete();
    sof_cyc_q.delete(); eof_cyc_q.delete();
    rd_cnt = 0; rd_first = -1; rd_last = -1; rd_gap = 0; inv_viol = 0;
    busy_rise = -1; busy_fall = -1;
  endtask

  task automatic do_reset;
    RST = 1'b1;
    tick; tick;
    RST = 1'b0;
    exp_frames = 0;
    exp_drops = 0;
  endtask

  task automatic start_frame(input int len, input bit badf, input int fill);
    for (int i = 0; i < fill; i++) mem[i] = 8'($urandom);
    rd_ptr = 0;
    FIFO_Data_Num = 11'(len);
    Frame_Bad = badf;
    New_Frame = 1'b1;
    tick;
    New_Frame = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit to);
    int n = 0;
    while (Busy && n < budget) begin
      tick;
      n++;
    end
    to = Busy;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    tick; tick; tick;
    total++;
    if ({RD_EN, Tx_Valid, Tx_SOF, Tx_EOF, Busy, Overrun} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b required 000000", {RD_EN, Tx_Valid, Tx_SOF, Tx_EOF, Busy, Overrun});
    end
    total++;
    if (Tx_Data !== 8'h00 || Frame_Cnt !== 16'd0 || Drop_Cnt !== 16'd0) begin
      bad++;
      $display("FAIL reset_values: Tx_Data=%h Frame_Cnt=%0d Drop_Cnt=%0d required all 0", Tx_Data, Frame_Cnt, Drop_Cnt);
    end
    RST = 1'b0;
    exp_frames = 0;
    exp_drops = 0;
    tick;
    total++;
    if (Busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: Busy=%b required 0", Busy);
    end
    $display("reset: flags=%b cnt=%0d/%0d", {RD_EN, Tx_Valid, Busy, Overrun}, Frame_Cnt, Drop_Cnt);
  endtask

  task automatic test_good(input int len, input int mode);
    bit to;
    int exp_n, err_d, err_s, err_e, first_bad;
    logic [7:0] exp_b;
    clear_mon();
    ready_mode = mode;
    start_frame(len, 1'b0, len);
    wait_idle(len * 8 + 200, to);
    tick;
    ready_mode = 0;
    if (exp_frames < 65535) exp_frames++;
    exp_n = len + NPRE;
    total++;
    if (to) begin
      bad++;
      $display("FAIL good_timeout: len=%0d Busy=%b after budget, required 0", len, Busy);
    end
    total++;
    if (obs_data.size() != exp_n) begin
      bad++;
      $display("FAIL good_beats: len=%0d got %0d beats required %0d", len, obs_data.size(), exp_n);
    end else begin
      err_d = 0; err_s = 0; err_e = 0; first_bad = -1;
      for (int i = 0; i < exp_n; i++) begin
        if (i < NPRE) exp_b = (i == NPRE - 1) ? 8'hD5 : 8'h55;
        else exp_b = mem[i - NPRE];
        if (obs_data[i] !== exp_b) begin
          err_d++;
          if (first_bad < 0) first_bad = i;
        end
        if (obs_sof[i] !== (i == 0)) err_s++;
        if (obs_eof[i] !== (i == exp_n - 1)) err_e++;
      end
      total++;
      if (err_d != 0) begin
        bad++;
        $display("FAIL good_data: len=%0d %0d wrong bytes (first at beat %0d), required 0", len, err_d, first_bad);
      end
      total++;
      if (err_s != 0) begin
        bad++;
        $display("FAIL good_sof: len=%0d %0d misplaced SOF flags, required 0", len, err_s);
      end
      total++;
      if (err_e != 0) begin
        bad++;
        $display("FAIL good_eof: len=%0d %0d misplaced EOF flags, required 0", len, err_e);
      end
    end
    total++;
    if (rd_cnt != len) begin
      bad++;
      $display("FAIL good_reads: len=%0d got %0d RD_EN cycles required %0d", len, rd_cnt, len);
    end
    total++;
    if (Frame_Cnt !== 16'(exp_frames) || Drop_Cnt !== 16'(exp_drops)) begin
      bad++;
      $display("FAIL good_counts: Frame_Cnt=%0d Drop_Cnt=%0d required %0d/%0d", Frame_Cnt, Drop_Cnt, exp_frames, exp_drops);
    end
    total++;
    if (inv_viol != 0) begin
      bad++;
      $display("FAIL good_idle_outputs: %0d cycles with Tx_Data/SOF/EOF set while Tx_Valid=0, required 0", inv_viol);
    end
    total++;
    if (eof_cyc_q.size() != 1 || busy_fall - eof_cyc_q[0] != IFG + 1) begin
      bad++;
      $display("FAIL good_ifg: eofs=%0d busy_fall-eof=%0d required 1 and %0d", eof_cyc_q.size(),
               (eof_cyc_q.size() > 0) ? busy_fall - eof_cyc_q[0] : -1, IFG + 1);
    end
    $display("good frame: len=%0d mode=%0d beats=%0d reads=%0d Frame_Cnt=%0d", len, mode, obs_data.size(), rd_cnt, Frame_Cnt);
  endtask

  task automatic test_drain(input int len, input bit badf);
    bit to;
    clear_mon();
    start_frame(len, badf, len);
    wait_idle(len + 50, to);
    tick;
    if (exp_drops < 65535) exp_drops++;
    total++;
    if (to) begin
      bad++;
      $display("FAIL drain_timeout: len=%0d Busy=%b after budget, required 0", len, Busy);
    end
    total++;
    if (rd_cnt != len || rd_gap != 0) begin
      bad++;
      $display("FAIL drain_reads: len=%0d got %0d reads with %0d gaps, required %0d with 0", len, rd_cnt, rd_gap, len);
    end
    total++;
    if (obs_data.size() != 0 || inv_viol != 0) begin
      bad++;
      $display("FAIL drain_no_tx: got %0d beats and %0d stray flags, required 0", obs_data.size(), inv_viol);
    end
    total++;
    if (busy_rise < 0 || busy_fall < 0 || busy_fall - busy_rise > len + 2) begin
      bad++;
      $display("FAIL drain_time: Busy span %0d cycles, required at most %0d", busy_fall - busy_rise, len + 2);
    end
    total++;
    if (Drop_Cnt !== 16'(exp_drops) || Frame_Cnt !== 16'(exp_frames)) begin
      bad++;
      $display("FAIL drain_counts: Drop_Cnt=%0d Frame_Cnt=%0d required %0d/%0d", Drop_Cnt, Frame_Cnt, exp_drops, exp_frames);
    end
    $display("drain frame: len=%0d bad=%0b reads=%0d Drop_Cnt=%0d", len, badf, rd_cnt, Drop_Cnt);
  endtask

  task automatic test_zero_len;
    bit to;
    clear_mon();
    start_frame(0, 1'b0, 0);
    wait_idle(20, to);
    tick;
    if (exp_drops < 65535) exp_drops++;
    total++;
    if (to || rd_cnt != 0 || obs_data.size() != 0) begin
      bad++;
      $display("FAIL zero_len: timeout=%0b reads=%0d beats=%0d required 0/0/0", to, rd_cnt, obs_data.size());
    end
    total++;
    if (Drop_Cnt !== 16'(exp_drops)) begin
      bad++;
      $display("FAIL zero_len_drop: Drop_Cnt=%0d required %0d", Drop_Cnt, exp_drops);
    end
    $display("zero frame: reads=%0d Drop_Cnt=%0d", rd_cnt, Drop_Cnt);
  endtask

  task automatic test_random(input int n);
    int len;
    bit badf;
    for (int k = 0; k < n; k++) begin
      len = $urandom_range(1, 300);
      badf = ($urandom_range(0, 3) == 0);
      if (badf || len < MINL || len > MAXL) test_drain(len, badf);
      else test_good(len, $urandom_range(0, 2));
    end
  endtask

  task automatic test_overrun;
    bit to;
    int len = 64;
    int exp_n, err, idx;
    logic [7:0] exp_b;
    do_reset();
    clear_mon();
    start_frame(len, 1'b0, 2 * len);
    repeat (20) tick;
    New_Frame = 1'b1; tick; New_Frame = 1'b0; tick;
    total++;
    if (Overrun !== 1'b0) begin
      bad++;
      $display("FAIL overrun_first: Overrun=%b after one queued frame, required 0", Overrun);
    end
    New_Frame = 1'b1; tick; New_Frame = 1'b0; tick;
    New_Frame = 1'b1; tick; New_Frame = 1'b0;
    total++;
    if (Overrun !== 1'b1) begin
      bad++;
      $display("FAIL overrun_flag: Overrun=%b required 1", Overrun);
    end
    wait_idle(1000, to);
    tick;
    total++;
    if (to || Busy !== 1'b1) begin
      bad++;
      $display("FAIL overrun_pending: timeout=%0b Busy=%b, required second frame started (Busy 1)", to, Busy);
    end
    wait_idle(1000, to);
    tick;
    exp_frames = 2;
    exp_n = 2 * (len + NPRE);
    total++;
    if (obs_data.size() != exp_n) begin
      bad++;
      $display("FAIL overrun_beats: got %0d beats required %0d", obs_data.size(), exp_n);
    end else begin
      err = 0;
      for (int f = 0; f < 2; f++) begin
        for (int i = 0; i < len + NPRE; i++) begin
          idx = f * (len + NPRE) + i;
          if (i < NPRE) exp_b = (i == NPRE - 1) ? 8'hD5 : 8'h55;
          else exp_b = mem[f * len + i - NPRE];
          if (obs_data[idx] !== exp_b || obs_sof[idx] !== (i == 0) || obs_eof[idx] !== (i == len + NPRE - 1)) err++;
        end
      end
      total++;
      if (err != 0) begin
        bad++;
        $display("FAIL overrun_stream: %0d wrong beats across two frames, required 0", err);
      end
    end
    total++;
    if (sof_cyc_q.size() != 2 || eof_cyc_q.size() != 2 || sof_cyc_q[1] - eof_cyc_q[0] <= IFG) begin
      bad++;
      $display("FAIL overrun_gap: sofs=%0d eofs=%0d, second SOF must come more than %0d cycles after first EOF",
               sof_cyc_q.size(), eof_cyc_q.size(), IFG);
    end
    total++;
    if (Frame_Cnt !== 16'(exp_frames) || Overrun !== 1'b1 || Busy !== 1'b0) begin
      bad++;
      $display("FAIL overrun_end: Frame_Cnt=%0d Overrun=%b Busy=%b required %0d/1/0", Frame_Cnt, Overrun, Busy, exp_frames);
    end
    $display("overrun: frames=%0d beats=%0d Overrun=%b", Frame_Cnt, obs_data.size(), Overrun);
  endtask

  task automatic test_reset_mid;
    int n = 0;
    int beats_snap, rd_snap;
    do_reset();
    clear_mon();
    start_frame(64, 1'b0, 64);
    while (obs_data.size() < NPRE + 30 && n < 300) begin
      tick;
      n++;
    end
    total++;
    if (obs_data.size() < NPRE + 30) begin
      bad++;
      $display("FAIL midreset_reach: only %0d beats seen, required %0d", obs_data.size(), NPRE + 30);
    end
    RST = 1'b1;
    tick;
    total++;
    if ({RD_EN, Tx_Valid, Tx_SOF, Tx_EOF, Busy, Overrun} !== 6'b0 || Tx_Data !== 8'h00) begin
      bad++;
      $display("FAIL midreset_outputs: flags=%b Tx_Data=%h required 000000/00", {RD_EN, Tx_Valid, Tx_SOF, Tx_EOF, Busy, Overrun}, Tx_Data);
    end
    RST = 1'b0;
    exp_frames = 0;
    exp_drops = 0;
    beats_snap = obs_data.size();
    rd_snap = rd_cnt;
    repeat (30) tick;
    total++;
    if (obs_data.size() != beats_snap || rd_cnt != rd_snap) begin
      bad++;
      $display("FAIL midreset_quiet: %0d beats and %0d reads after reset, required 0", obs_data.size() - beats_snap, rd_cnt - rd_snap);
    end
    total++;
    if (Frame_Cnt !== 16'd0 || Drop_Cnt !== 16'd0 || Busy !== 1'b0) begin
      bad++;
      $display("FAIL midreset_counts: Frame_Cnt=%0d Drop_Cnt=%0d Busy=%b required 0/0/0", Frame_Cnt, Drop_Cnt, Busy);
    end
    $display("mid reset: beats_before=%0d Frame_Cnt=%0d Drop_Cnt=%0d", beats_snap, Frame_Cnt, Drop_Cnt);
  endtask

  initial begin
    test_reset();
    test_good(64, 0);
    test_good(80, 1);
    do_reset();
    test_drain(100, 1'b1);
    do_reset();
    test_drain(40, 1'b0);
    test_drain(1600, 1'b0);
    test_drain(63, 1'b0);
    test_good(MINL, 2);
    test_good(MAXL, 0);
    test_drain(MAXL + 1, 1'b0);
    test_zero_len();
    test_random(8);
    test_overrun();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_tx_scheduler.md
FRAME_TX_SCHEDULER -- requirements
Module: frame_tx_scheduler

Interface
REQ-001 SHALL provide parameter IFG_CYCLES, default 12: idle cycles enforced after each forwarded frame.
REQ-002 SHALL provide parameter MIN_LEN, default 64: smallest forwardable frame, in bytes.
REQ-003 SHALL provide parameter MAX_LEN, default 1518: largest forwardable frame, in bytes.
REQ-004 SHALL provide parameter PREAMBLE_EN, default 1: when 1, prepend 7x 0x55 plus 0xD5 to every forwarded frame.
REQ-005 SHALL have RAM_Clk_Read  in  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have RST  in  1  reset; one clock, reset synchronous and active-high.
REQ-007 SHALL have New_Frame  in  1  one-cycle pulse: a complete frame is available in the receive buffer.
REQ-008 SHALL have FIFO_Data_Num  in  11  byte count of the available frame.
REQ-009 SHALL have RAM_Dataout  in  8  buffer read data, valid the cycle after RD_EN.
REQ-010 SHALL have Frame_Bad  in  1  level, already synchronised; high means the available frame failed CRC.
REQ-011 SHALL have Tx_Ready  in  1  downstream permission to start one byte this cycle.
REQ-012 SHALL have RD_EN  out  1  buffer read request.
REQ-013 SHALL have Tx_Data  out  8  byte to transmitter.
REQ-014 SHALL have Tx_Valid  out  1  Tx_Data valid this cycle.
REQ-015 SHALL have Tx_SOF  out  1  first byte of a frame (first preamble byte, or first data byte if PREAMBLE_EN=0).
REQ-016 SHALL have Tx_EOF  out  1  last data byte of a frame.
REQ-017 SHALL have Busy  out  1  high whenever state is not IDLE.
REQ-018 SHALL have Frame_Cnt  out  16  count of frames forwarded.
REQ-019 SHALL have Drop_Cnt  out  16  count of frames dropped.
REQ-020 SHALL have Overrun  out  1  sticky: a New_Frame arrived while a pending frame was already latched.

Function
REQ-021 SHALL use states IDLE, LOAD, PRE, DATA, DRAIN, IFG.
REQ-022 IDLE: on New_Frame, or if the pending flag is set, SHALL go to LOAD and clear pending.
REQ-023 LOAD: SHALL capture FIFO_Data_Num into an 11-bit length register and sample Frame_Bad.
REQ-024 LOAD: length 0 -> IDLE with Drop_Cnt+1 and no reads.
REQ-025 LOAD: Frame_Bad=1, length<MIN_LEN or length>MAX_LEN -> DRAIN.
REQ-026 LOAD: otherwise -> PRE if PREAMBLE_EN=1, else DATA.
REQ-027 PRE: SHALL emit one preamble byte per cycle with Tx_Ready=1 (Tx_Valid=1), stall while Tx_Ready=0, then go to DATA after 0xD5.
REQ-028 DATA: SHALL assert RD_EN only in cycles where Tx_Ready=1 and remaining>0, decrementing remaining per read.
REQ-029 DATA: each issued read SHALL produce exactly one Tx_Valid beat carrying RAM_Dataout one cycle later, regardless of Tx_Ready in that later cycle.
REQ-030 DATA: Tx_EOF SHALL accompany the beat of the final read; Frame_Cnt+1 on that beat; next state IFG.
REQ-031 DRAIN: SHALL assert RD_EN for exactly length consecutive cycles, ignore Tx_Ready, keep Tx_Valid=0, then Drop_Cnt+1 and go to IDLE (no IFG).
REQ-032 IFG: SHALL hold Tx_Valid=0 and RD_EN=0 for IFG_CYCLES cycles counted from the cycle after the Tx_EOF beat, then go to IDLE.
REQ-033 New_Frame while Busy SHALL set pending; if pending was already set, SHALL set Overrun and leave pending set.
REQ-034 New_Frame in IDLE in the same cycle pending is set SHALL consume one frame and keep pending.
REQ-035 Frame_Cnt and Drop_Cnt SHALL saturate at 0xFFFF.
REQ-036 Tx_Data SHALL be 0x00 whenever Tx_Valid=0.
REQ-037 Tx_SOF and Tx_EOF SHALL only be high together with Tx_Valid; with PREAMBLE_EN=0 and length 1 (MIN_LEN permitting), both SHALL be high on the same beat.
REQ-038 RD_EN SHALL never be asserted outside DATA or DRAIN.

Reset
REQ-039 With RST=1 at a clock edge: state SHALL become IDLE; RD_EN, Tx_Valid, Tx_SOF, Tx_EOF, Busy, Overrun, pending SHALL become 0; Tx_Data, Frame_Cnt, Drop_Cnt SHALL become 0.
REQ-040 RST asserted mid-frame SHALL abort with no further RD_EN or Tx_Valid from the next cycle, and no counter update for the aborted frame.

Verification
REQ-041 Good 64-byte frame, Tx_Ready=1, PREAMBLE_EN=1 -> 8 preamble beats, then 64 data beats matching buffer contents, Tx_EOF on beat 72, Frame_Cnt=1, then 12 idle cycles.
REQ-042 Frame_Bad=1 with length 100 -> 100 consecutive RD_EN cycles, zero Tx_Valid, Drop_Cnt=1, Busy low within 102 cycles of LOAD.
REQ-043 Good 80-byte frame, Tx_Ready toggling 1/0 every cycle -> exactly 80 RD_EN pulses, 80 in-order data beats, no duplicates or losses.
REQ-044 Length 40 and length 1600 -> both drained, Drop_Cnt=2, Frame_Cnt=0.
REQ-045 Three New_Frame pulses during one transfer -> pending set, Overrun=1; second frame starts only after IFG completes.
REQ-046 RST=1 at data byte 30 of a 64-byte frame -> all outputs 0 on the next cycle, both counters 0.
